// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: a two-cycle fetch/present loop feeding decode, with backpressure,
// branch redirect on accepted instructions and a sticky halt that only reset clears.
module instr_fetch_unit #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [4:0] HALT_OPCODE = 5'b11111
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    output logic [7:0]  o_addr_bus,
    input  logic [16:0] i_instr_in,
    output logic [16:0] o_ir_out,
    output logic [7:0]  o_ir_pc,
    output logic        o_ir_valid,
    input  logic        i_ir_ready,
    input  logic        i_branch_en,
    input  logic [7:0]  i_branch_addr,
    output logic        o_halted,
    output logic [7:0]  o_fetch_count
);

    typedef enum logic [1:0] {StIdle, StFetch, StValid, StHalted} state_e;

    state_e      r_state, w_state_d;
    logic [7:0]  r_pc, w_pc_d;
    logic [16:0] r_ir, w_ir_d;
    logic [7:0]  r_ir_pc, w_ir_pc_d;
    logic [7:0]  r_count, w_count_d;
    logic        w_accept;

    assign w_accept = (r_state == StValid) && i_ir_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_ir_pc <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_d;
            r_pc    <= w_pc_d;
            r_ir    <= w_ir_d;
            r_ir_pc <= w_ir_pc_d;
            r_count <= w_count_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_pc_d    = r_pc;
        w_ir_d    = r_ir;
        w_ir_pc_d = r_ir_pc;
        w_count_d = r_count;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d = StFetch;
                end
            end
            StFetch: begin
                w_ir_d    = i_instr_in;
                w_ir_pc_d = r_pc;
                w_pc_d    = r_pc + 8'd1;
                w_state_d = StValid;
            end
            StValid: begin
                if (w_accept) begin
                    w_count_d = r_count + 8'd1;
                    // Halt wins over a branch on the same instruction.
                    if (r_ir[16:12] == HALT_OPCODE) begin
                        w_state_d = StHalted;
                    end else begin
                        if (i_branch_en) begin
                            w_pc_d = i_branch_addr;
                        end
                        w_state_d = StFetch;
                    end
                end
            end
            StHalted: begin
                w_state_d = StHalted;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign o_addr_bus    = r_pc;
    assign o_ir_out      = r_ir;
    assign o_ir_pc       = r_ir_pc;
    assign o_ir_valid    = (r_state == StValid);
    assign o_halted      = (r_state == StHalted);
    assign o_fetch_count = r_count;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 8'h00: PC value loaded on reset.
REQ-002 Parameter HALT_OPCODE, default 5'b11111: opcode field (instr[16:12]) that stops fetching.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  level; begins fetching from IDLE.
REQ-006 Addr_Bus  output  8  program memory address, driven directly from the PC register.
REQ-007 Instr_In  input  17  instruction word from program memory DataOut_Bus; combinational read, valid within the cycle Addr_Bus is stable.
REQ-008 ir_out  output  17  captured instruction presented to decode.
REQ-009 ir_pc  output  8  address from which ir_out was fetched.
REQ-010 ir_valid  output  1  ir_out/ir_pc hold a valid instruction.
REQ-011 ir_ready  input  1  decode accepts ir_out this cycle.
REQ-012 branch_en  input  1  redirect request, qualified with the accepted instruction.
REQ-013 branch_addr  input  8  redirect target.
REQ-014 halted  output  1  HALT instruction consumed; fetching stopped.
REQ-015 fetch_count  output  8  number of instructions accepted by decode since reset, wraps 255->0.

Function
REQ-016 States SHALL be IDLE, FETCH, VALID, HALTED; state is registered.
REQ-017 IDLE: ir_valid=0; start=1 -> FETCH; else stay.
REQ-018 FETCH (exactly one cycle): Addr_Bus=PC; on the edge, ir_out<=Instr_In, ir_pc<=PC, PC<=PC+1 (mod 256), -> VALID.
REQ-019 VALID: ir_valid=1; ir_out, ir_pc, PC held stable while ir_ready=0 (backpressure, unbounded wait).
REQ-020 VALID with ir_ready=1 (accept): fetch_count+1; if ir_out[16:12]==HALT_OPCODE -> HALTED; else if branch_en=1 -> PC<=branch_addr, -> FETCH; else -> FETCH.
REQ-021 HALT takes priority over branch_en on the same accepted instruction; branch_addr is ignored.
REQ-022 branch_en/branch_addr SHALL be ignored in every case other than REQ-020 accept.
REQ-023 start is ignored outside IDLE.
REQ-024 HALTED: ir_valid=0, halted=1, PC frozen, Addr_Bus frozen; only reset exits.
REQ-025 Throughput: one instruction per 2 cycles with ir_ready held high; first ir_valid is the 2nd cycle after the start=1 cycle in IDLE.
REQ-026 PC 8'hFF increments to 8'h00; no error flag.
REQ-027 Branch to the address just fetched (self-loop) SHALL refetch it normally.
REQ-028 ir_valid SHALL never be asserted in the same cycle as halted.

Reset
REQ-029 With rst_n=0 at an edge: state=IDLE, PC=RESET_PC, Addr_Bus=RESET_PC, ir_out=0, ir_pc=0, ir_valid=0, halted=0, fetch_count=0.
REQ-030 Reset overrides all inputs and SHALL abort any state, including VALID awaiting ir_ready; the pending instruction is discarded and not counted.

Verification
REQ-031 Memory word0=17'h0B441, ready=1, start pulse -> Addr_Bus=0, next cycle ir_out=17'h0B441, ir_pc=0, ir_valid=1; Addr_Bus=1 after accept.
REQ-032 ir_ready=0 for 5 cycles in VALID -> ir_out, ir_pc, Addr_Bus, fetch_count unchanged; accept on 6th cycle -> fetch_count+1.
REQ-033 Accept word at addr 3 with branch_en=1, branch_addr=8'h20 -> next FETCH Addr_Bus=8'h20, next ir_pc=8'h20; branch_en pulsed in FETCH is ignored.
REQ-034 Word at addr 2 has opcode 5'b11111, branch_en=1 -> halted=1, ir_valid=0, Addr_Bus=3, fetch_count=3, no further fetch despite start.
REQ-035 Branch to 8'hFF -> ir_pc=8'hFF, next Addr_Bus=8'h00; rst_n=0 during VALID -> all REQ-029 values next cycle.
